// File: rtl/cisc_control.sv
// cisc_control: microsequencer for the SimpleCISC datapath.
// Registered five-state FSM; every strobe is decoded combinationally from state, IR, ZReg and Ready.
module cisc_control #(
    parameter logic [3:0] F_PASSB = 4'h0,
    parameter logic [3:0] F_ADD   = 4'h1,
    parameter logic [3:0] F_SUB   = 4'h2
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic [15:0] IR,
    input  logic        ZReg,
    input  logic        Ready,
    output logic [3:0]  Function,
    output logic        UpdateZ,
    output logic        EnableACC,
    output logic        EnableX,
    output logic        EnableS,
    output logic        EnablePC,
    output logic        LoadACC,
    output logic        LoadX,
    output logic        LoadS,
    output logic        LoadPC,
    output logic        IncPC,
    output logic        SelPC,
    output logic        LoadIR,
    output logic        LoadMAR,
    output logic        EnableReg,
    output logic        nOE,
    output logic        nWE,
    output logic        Halted
);

    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JZ   = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] SEL_ACC = 2'b00;
    localparam logic [1:0] SEL_X   = 2'b01;
    localparam logic [1:0] SEL_S   = 2'b10;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_OPERAND = 3'd2,
        ST_EXEC    = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [3:0] w_op;
    logic [1:0] w_sel;
    logic       w_is_ld;
    logic       w_is_st;
    logic       w_is_add;
    logic       w_is_sub;
    logic       w_is_jmp;
    logic       w_is_jz;
    logic       w_is_halt;
    logic       w_is_mem;
    logic       w_sel_ok;
    logic       w_unused_ir;

    assign w_op        = IR[15:12];
    assign w_sel       = IR[11:10];
    assign w_is_ld     = (w_op == OP_LD);
    assign w_is_st     = (w_op == OP_ST);
    assign w_is_add    = (w_op == OP_ADD);
    assign w_is_sub    = (w_op == OP_SUB);
    assign w_is_jmp    = (w_op == OP_JMP);
    assign w_is_jz     = (w_op == OP_JZ);
    assign w_is_halt   = (w_op == OP_HALT);
    assign w_is_mem    = w_is_ld | w_is_st | w_is_add | w_is_sub;
    assign w_sel_ok    = (w_sel != 2'b11);
    assign w_unused_ir = &{1'b0, IR[9:0]};

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        Function     = F_PASSB;
        UpdateZ      = 1'b0;
        EnableACC    = 1'b0;
        EnableX      = 1'b0;
        EnableS      = 1'b0;
        EnablePC     = 1'b0;
        LoadACC      = 1'b0;
        LoadX        = 1'b0;
        LoadS        = 1'b0;
        LoadPC       = 1'b0;
        IncPC        = 1'b0;
        SelPC        = 1'b1;
        LoadIR       = 1'b0;
        LoadMAR      = 1'b0;
        EnableReg    = 1'b0;
        nOE          = 1'b1;
        nWE          = 1'b1;
        Halted       = 1'b0;

        case (r_state)
            ST_RESET: begin
                w_state_next = ST_FETCH;
            end

            ST_FETCH: begin
                nOE = 1'b0;
                if (Ready) begin
                    LoadIR       = 1'b1;
                    IncPC        = 1'b1;
                    w_state_next = ST_OPERAND;
                end
            end

            // The opcode only becomes visible once IR has latched, so NOP and
            // HALT resolve here in a single bus-idle cycle.
            ST_OPERAND: begin
                if (w_is_halt) begin
                    w_state_next = ST_HALT;
                end else if (w_is_mem) begin
                    nOE = 1'b0;
                    if (Ready) begin
                        LoadMAR      = 1'b1;
                        IncPC        = 1'b1;
                        w_state_next = ST_EXEC;
                    end
                end else if (w_is_jmp) begin
                    nOE = 1'b0;
                    if (Ready) begin
                        LoadPC       = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                end else if (w_is_jz) begin
                    nOE = 1'b0;
                    if (Ready) begin
                        LoadPC       = ZReg;
                        IncPC        = ~ZReg;
                        w_state_next = ST_FETCH;
                    end
                end else begin
                    w_state_next = ST_FETCH;
                end
            end

            ST_EXEC: begin
                SelPC = 1'b0;
                if (w_is_ld && w_sel_ok) begin
                    nOE     = 1'b0;
                    UpdateZ = Ready;
                    LoadACC = Ready && (w_sel == SEL_ACC);
                    LoadX   = Ready && (w_sel == SEL_X);
                    LoadS   = Ready && (w_sel == SEL_S);
                    if (Ready) begin
                        w_state_next = ST_FETCH;
                    end
                end else if (w_is_st && w_sel_ok) begin
                    nWE       = 1'b0;
                    EnableReg = 1'b1;
                    EnableACC = (w_sel == SEL_ACC);
                    EnableX   = (w_sel == SEL_X);
                    EnableS   = (w_sel == SEL_S);
                    if (Ready) begin
                        w_state_next = ST_FETCH;
                    end
                end else if (w_is_add || w_is_sub) begin
                    nOE       = 1'b0;
                    EnableACC = 1'b1;
                    Function  = w_is_add ? F_ADD : F_SUB;
                    LoadACC   = Ready;
                    UpdateZ   = Ready;
                    if (Ready) begin
                        w_state_next = ST_FETCH;
                    end
                end else begin
                    // Reserved register select: operand already consumed, no bus cycle.
                    w_state_next = ST_FETCH;
                end
            end

            ST_HALT: begin
                Halted = 1'b1;
            end

            default: begin
                w_state_next = ST_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_cisc_control.sv
// tb_cisc_control: drives cisc_control through a behavioural datapath/memory and
// checks architectural results against an instruction-level interpreter.
module tb_cisc_control;

    logic        Clock = 1'b0;
    logic        nReset = 1'b1;
    logic [15:0] IR;
    logic        ZReg;
    logic        Ready = 1'b0;
    logic [3:0]  Function;
    logic        UpdateZ, EnableACC, EnableX, EnableS, EnablePC;
    logic        LoadACC, LoadX, LoadS, LoadPC, IncPC, SelPC, LoadIR, LoadMAR;
    logic        EnableReg, nOE, nWE, Halted;

    always #5 Clock = ~Clock;

    cisc_control dut (
        .Clock(Clock), .nReset(nReset), .IR(IR), .ZReg(ZReg), .Ready(Ready),
        .Function(Function), .UpdateZ(UpdateZ),
        .EnableACC(EnableACC), .EnableX(EnableX), .EnableS(EnableS), .EnablePC(EnablePC),
        .LoadACC(LoadACC), .LoadX(LoadX), .LoadS(LoadS), .LoadPC(LoadPC),
        .IncPC(IncPC), .SelPC(SelPC), .LoadIR(LoadIR), .LoadMAR(LoadMAR),
        .EnableReg(EnableReg), .nOE(nOE), .nWE(nWE), .Halted(Halted)
    );

    // Behavioural datapath and memory
    logic [15:0] mem [0:255];
    logic [15:0] acc, xr, sr, pc, mar;
    logic [15:0] regbus, address, databus, alu;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = 8'h0;
    logic [15:0] ld_data = 16'h0;

    always_comb begin
        regbus = 16'h0;
        if (EnableACC)     regbus = acc;
        else if (EnableX)  regbus = xr;
        else if (EnableS)  regbus = sr;
        else if (EnablePC) regbus = pc;
        address = SelPC ? pc : mar;
        databus = 16'h0;
        if (!nOE)           databus = mem[address[7:0]];
        else if (EnableReg) databus = regbus;
        alu = databus;
        case (Function)
            4'h1:    alu = regbus + databus;
            4'h2:    alu = regbus - databus;
            default: alu = databus;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            IR <= 16'h0; pc <= 16'h0; mar <= 16'h0;
            acc <= 16'h0; xr <= 16'h0; sr <= 16'h0; ZReg <= 1'b0;
        end else begin
            if (LoadIR)  IR  <= databus;
            if (LoadMAR) mar <= databus;
            if (LoadPC)      pc <= databus;
            else if (IncPC)  pc <= pc + 16'h1;
            if (LoadACC) acc <= alu;
            if (LoadX)   xr  <= alu;
            if (LoadS)   sr  <= alu;
            if (UpdateZ) ZReg <= (alu == 16'h0);
        end
    end

    always_ff @(posedge Clock) begin
        if (ld_en)              mem[ld_addr] <= ld_data;
        else if (!nWE && Ready) mem[address[7:0]] <= databus;
    end

    // Bench state
    int          tests = 0;
    int          fails = 0;
    int          accesses = 0;
    int          we_windows = 0;
    logic        nwe_prev = 1'b1;
    bit          rdy_force = 1'b0;
    logic        rdy_val = 1'b1;
    logic [15:0] img  [0:255];
    logic [15:0] rmem [0:255];
    logic [15:0] ref_pc, ref_acc, ref_x, ref_s;
    logic        ref_z;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle bus rules, then advance one clock and set Ready for the new cycle.
    task automatic tick();
        check("strobe_excl", {31'b0, (!nOE && !nWE)}, 32'h0);
        check("one_enable", {31'b0, ($countones({EnableACC, EnableX, EnableS, EnablePC}) <= 1)}, 32'h1);
        check("inc_with_load", {31'b0, (IncPC && LoadPC)}, 32'h0);
        if (!Ready)
            check("load_while_wait", {24'b0, LoadIR, LoadMAR, LoadPC, LoadACC, LoadX, LoadS, IncPC, UpdateZ}, 32'h0);
        if (!nOE && Ready) accesses++;
        if (!nWE && nwe_prev) we_windows++;
        nwe_prev = nWE;
        @(posedge Clock);
        #1;
        Ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        #1;
    endtask

    task automatic clear_img();
        for (int a = 0; a < 256; a++) img[a] = 16'h0;
    endtask

    task automatic load_image();
        nReset = 1'b0;
        for (int a = 0; a < 256; a++) begin
            @(posedge Clock);
            #1;
            ld_en = 1'b1; ld_addr = 8'(a); ld_data = img[a];
        end
        @(posedge Clock);
        #1;
        ld_en = 1'b0;
        #1;
        accesses = 0; we_windows = 0; nwe_prev = 1'b1;
    endtask

    task automatic run_until_halt(input int budget);
        int c = 0;
        while (!Halted && c < budget) begin
            tick();
            c++;
        end
        check("halt_reached", {31'b0, Halted}, 32'h1);
    endtask

    // Instruction-level interpreter of the ISA
    task automatic ref_run();
        logic [15:0] w, a, v;
        logic [3:0]  o;
        logic [1:0]  sl;
        ref_pc = 16'h0; ref_acc = 16'h0; ref_x = 16'h0; ref_s = 16'h0; ref_z = 1'b0;
        for (int k = 0; k < 100; k++) begin
            w = rmem[ref_pc[7:0]];
            o = w[15:12];
            sl = w[11:10];
            ref_pc = ref_pc + 16'h1;
            if (o == 4'hF) break;
            if (o < 4'h1 || o > 4'h6) continue;
            a = rmem[ref_pc[7:0]];
            ref_pc = ref_pc + 16'h1;
            case (o)
                4'h1: if (sl != 2'b11) begin
                    v = rmem[a[7:0]];
                    if (sl == 2'b00) ref_acc = v; else if (sl == 2'b01) ref_x = v; else ref_s = v;
                    ref_z = (v == 16'h0);
                end
                4'h2: if (sl != 2'b11)
                    rmem[a[7:0]] = (sl == 2'b00) ? ref_acc : (sl == 2'b01) ? ref_x : ref_s;
                4'h3: begin ref_acc = ref_acc + rmem[a[7:0]]; ref_z = (ref_acc == 16'h0); end
                4'h4: begin ref_acc = ref_acc - rmem[a[7:0]]; ref_z = (ref_acc == 16'h0); end
                4'h5: ref_pc = a;
                default: if (ref_z) ref_pc = a;
            endcase
        end
    endtask

    // Random forward-branching program ending in HALT; data lives at 0x80-0x8F.
    task automatic gen_program(output int words);
        int n, k, j;
        int opc [16];
        int start [17];
        n = $urandom_range(4, 14);
        start[0] = 0;
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 8:    opc[i] = 1;
                1:       opc[i] = 2;
                2, 9:    opc[i] = 3;
                3:       opc[i] = 4;
                4:       opc[i] = 5;
                5:       opc[i] = 6;
                6:       opc[i] = 0;
                default: opc[i] = $urandom_range(7, 14);
            endcase
            start[i+1] = start[i] + ((opc[i] >= 1 && opc[i] <= 6) ? 2 : 1);
        end
        clear_img();
        for (int a = 8'h80; a < 8'h90; a++)
            img[a] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
        for (int i = 0; i < n; i++) begin
            img[start[i]] = {4'(opc[i]), 2'($urandom_range(0, 3)), 10'($urandom)};
            if (opc[i] >= 1 && opc[i] <= 4) begin
                img[start[i] + 1] = 16'(8'h80 + $urandom_range(0, 15));
            end else if (opc[i] == 5 || opc[i] == 6) begin
                j = $urandom_range(i + 1, n);
                img[start[i] + 1] = 16'(start[j]);
            end
        end
        img[start[n]] = {4'hF, 12'($urandom)};
        words = start[n] + 1;
    endtask

    initial begin
        int words;
        logic [15:0] pc_hold;
        #1 nReset = 1'b0;

        // Reset state and first LD (ACC <- 0 sets Z)
        clear_img();
        img[0] = 16'h1000; img[1] = 16'h0010; img[16'h10] = 16'h0; img[2] = 16'hF000;
        rdy_force = 1'b1; rdy_val = 1'b1;
        load_image();
        check("rst_noe", {31'b0, nOE}, 32'h1);
        check("rst_nwe", {31'b0, nWE}, 32'h1);
        check("rst_selpc", {31'b0, SelPC}, 32'h1);
        check("rst_func", {28'b0, Function}, 32'h0);
        check("rst_halted", {31'b0, Halted}, 32'h0);
        check("rst_ctl", {19'b0, LoadIR, LoadMAR, LoadPC, LoadACC, LoadX, LoadS, IncPC, UpdateZ,
                          EnableACC, EnableX, EnableS, EnablePC, EnableReg}, 32'h0);
        nReset = 1'b1;
        for (int c = 0; c < 20 && accesses < 3; c++) tick();
        check("ld_pc", {16'b0, pc}, 32'h2);
        check("ld_acc", {16'b0, acc}, 32'h0);
        check("ld_z", {31'b0, ZReg}, 32'h1);
        run_until_halt(50);
        $display("[TB] directed LD ACC: pc=%h acc=%h z=%b", pc, acc, ZReg);

        // Ready held low for three FETCH cycles
        clear_img();
        img[0] = 16'h0ABC; img[1] = 16'hF000;
        rdy_force = 1'b1; rdy_val = 1'b0;
        load_image();
        nReset = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("fetch_wait_noe", {31'b0, nOE}, 32'h0);
            check("fetch_wait_pulse", {30'b0, LoadIR, IncPC}, 32'h0);
            if (k == 2) rdy_val = 1'b1;
            tick();
        end
        check("fetch_go_pulse", {30'b0, LoadIR, IncPC}, 32'h3);
        check("fetch_go_pc", {16'b0, pc}, 32'h0);
        tick();
        check("fetch_pc_once", {16'b0, pc}, 32'h1);
        check("fetch_ir", {16'b0, IR}, 32'h0ABC);
        run_until_halt(50);
        check("nop_halt_pc", {16'b0, pc}, 32'h2);
        $display("[TB] directed FETCH wait: pc=%h ir=%h", pc, IR);

        // ST X to 0x20 with random wait states
        clear_img();
        img[0] = 16'h1400; img[1] = 16'h0030; img[2] = 16'h2400; img[3] = 16'h0020;
        img[4] = 16'hF000; img[16'h30] = 16'h1234;
        rdy_force = 1'b0;
        load_image();
        nReset = 1'b1;
        for (int c = 0; c < 300 && !Halted; c++) begin
            if (!nWE) begin
                check("st_data", {16'b0, databus}, 32'h1234);
                check("st_addr", {16'b0, address}, 32'h20);
                check("st_noe", {31'b0, nOE}, 32'h1);
            end
            tick();
        end
        check("st_halt", {31'b0, Halted}, 32'h1);
        check("st_windows", we_windows, 32'h1);
        check("st_mem", {16'b0, mem[8'h20]}, 32'h1234);
        $display("[TB] directed ST X: mem[20]=%h windows=%0d", mem[8'h20], we_windows);

        // JZ taken and not taken
        for (int t = 0; t < 2; t++) begin
            clear_img();
            img[0] = 16'h1000; img[1] = 16'h0030; img[2] = 16'h6000; img[3] = 16'h0040;
            img[4] = 16'hF000; img[16'h40] = 16'hF000;
            img[16'h30] = (t == 0) ? 16'h0 : 16'h7;
            load_image();
            nReset = 1'b1;
            run_until_halt(300);
            check("jz_pc", {16'b0, pc}, (t == 0) ? 32'h41 : 32'h5);
            $display("[TB] directed JZ z=%0d: pc=%h", (t == 0), pc);
        end

        // ADD then SUB twice against M=5
        clear_img();
        img[0]  = 16'h1000; img[1]  = 16'h0030; img[2]  = 16'h3000; img[3]  = 16'h0030;
        img[4]  = 16'h2000; img[5]  = 16'h0031; img[6]  = 16'h4000; img[7]  = 16'h0030;
        img[8]  = 16'h2000; img[9]  = 16'h0032; img[10] = 16'h4000; img[11] = 16'h0030;
        img[12] = 16'hF000; img[16'h30] = 16'h5;
        load_image();
        nReset = 1'b1;
        run_until_halt(500);
        check("add_res", {16'b0, mem[8'h31]}, 32'hA);
        check("sub_res", {16'b0, mem[8'h32]}, 32'h5);
        check("sub_zero_acc", {16'b0, acc}, 32'h0);
        check("sub_zero_z", {31'b0, ZReg}, 32'h1);
        check("arith_pc", {16'b0, pc}, 32'hD);
        $display("[TB] directed ADD/SUB: m31=%h m32=%h acc=%h z=%b", mem[8'h31], mem[8'h32], acc, ZReg);

        // HALT is sticky and bus-idle
        pc_hold = pc;
        for (int c = 0; c < 20; c++) begin
            check("halt_idle", {29'b0, nOE, nWE, Halted}, 32'h7);
            tick();
        end
        check("halt_pc", {16'b0, pc}, {16'b0, pc_hold});
        $display("[TB] directed HALT hold: pc=%h", pc);

        // nReset pulse in the middle of an EXEC wait
        clear_img();
        img[0] = 16'h1000; img[1] = 16'h0030; img[2] = 16'hF000; img[16'h30] = 16'hBEEF;
        rdy_force = 1'b1; rdy_val = 1'b1;
        load_image();
        nReset = 1'b1;
        tick();
        tick();
        rdy_val = 1'b0;
        tick();
        check("exec_busy", {30'b0, SelPC, nOE}, 32'h0);
        #1 nReset = 1'b0;
        #1;
        check("rst_async_strobes", {29'b0, nOE, nWE, SelPC}, 32'h7);
        check("rst_async_load", {30'b0, LoadACC, UpdateZ}, 32'h0);
        #1 nReset = 1'b1;
        rdy_val = 1'b1;
        tick();
        check("rst_refetch", {15'b0, nOE, address}, 32'h0);
        check("rst_no_partial", {16'b0, acc}, 32'h0);
        run_until_halt(50);
        check("rst_rerun_acc", {16'b0, acc}, 32'hBEEF);
        $display("[TB] directed reset mid-EXEC: acc=%h", acc);

        // Random programs against the interpreter
        for (int p = 0; p < 15; p++) begin
            gen_program(words);
            for (int a = 0; a < 256; a++) rmem[a] = img[a];
            ref_run();
            rdy_force = 1'b0;
            load_image();
            nReset = 1'b1;
            run_until_halt(1500);
            check("rnd_pc", {16'b0, pc}, {16'b0, ref_pc});
            check("rnd_acc", {16'b0, acc}, {16'b0, ref_acc});
            check("rnd_x", {16'b0, xr}, {16'b0, ref_x});
            check("rnd_s", {16'b0, sr}, {16'b0, ref_s});
            check("rnd_z", {31'b0, ZReg}, {31'b0, ref_z});
            for (int a = 8'h80; a < 8'h90; a++)
                check("rnd_mem", {16'b0, mem[a]}, {16'b0, rmem[a]});
            $display("[TB] random program %0d: %0d words, pc=%h acc=%h x=%h s=%h z=%b",
                     p, words, pc, acc, xr, sr, ZReg);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
